key_sched_gen: RTL

Sequential AES key-schedule generator for AES-128/192/256. It takes a full cipher key and streams the expanded round-key words w[0..4·(NR+1)−1] one 32-bit word per handshake. Word rotation, SubWord and Rcon are applied in hardware. It sits between the key register and the round-key store/cipher core, and replaces the combinational per-word rotate helper used by the fixed AES-128 datapath.

---
 rtl/aes_pkg.sv | 40 ++++
 rtl/sub_word.sv | 12 +
 rtl/key_sched_gen.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: word/byte types, FSM state encoding, the Rcon
// seed, GF(2^8) doubling (xtime) and the forward S-box table.
package aes_pkg;

  typedef logic [31:0] word_t;
  typedef logic [7:0]  byte_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2
  } state_t;

  localparam byte_t RCON_INIT = 8'h01;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/sub_word.sv
// SubWord: four parallel forward S-box lookups on a 32-bit word.
// Purely combinational.
module sub_word
  import aes_pkg::*;
(
  input  word_t src,
  output word_t sub
);

  assign sub = {SBOX[src[31:24]], SBOX[src[23:16]], SBOX[src[15:8]], SBOX[src[7:0]]};

endmodule

// File: rtl/key_sched_gen.sv
// Sequential AES key-schedule generator (AES-128/192/256 selected by NK).
// Streams w[0..NW-1] one word per valid/ready handshake. The output word is
// registered; the next word is computed one step ahead from an NK-word
// window holding the most recent words, newest at window[NK-1].
// Optional feature: define KEY_SCHED_ABORT_EN to add the abort input.
module key_sched_gen
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [32*NK-1:0] key,
  output logic            ready,
  output logic            wvalid,
  input  logic            wready,
  output word_t           word,
  output logic [5:0]      word_idx,
  output logic            done
`ifdef KEY_SCHED_ABORT_EN
  ,
  input  logic            abort
`endif
);

  localparam int         NR         = NK + 6;
  localparam int         NW         = 4 * (NR + 1);
  localparam logic [5:0] LOAD_LAST  = 6'(NK - 1);
  localparam logic [5:0] LAST_IDX   = 6'(NW - 1);
  localparam logic [2:0] PHASE_LAST = 3'(NK - 1);
  localparam logic [2:0] PHASE_INIT = 3'(1 % NK);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_nk_check
    $error("key_sched_gen: NK must be 4, 6 or 8");
  end

  state_t     state, state_nxt;
  word_t      window [NK];
  byte_t      rcon;
  logic [2:0] phase;      // (word_idx + 1) mod NK: position of the next word
  logic       abort_req;
  logic       xfer;
  logic       from_key;   // next word still comes straight from the key
  logic       use_rcon;
  word_t      newest, oldest, sw_in, sw_out, temp, exp_word, load_word, next_word;

`ifdef KEY_SCHED_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign ready    = (state == IDLE);
  assign xfer     = wvalid && wready;
  assign newest   = window[NK-1];
  assign oldest   = window[0];
  assign use_rcon = (phase == 3'd0);
  assign from_key = (state == LOAD) && (word_idx != LOAD_LAST);

  // RotWord is a plain byte reorder ahead of the single SubWord instance.
  assign sw_in = use_rcon ? {newest[23:0], newest[31:24]} : newest;

  sub_word u_sub_word (
    .src (sw_in),
    .sub (sw_out)
  );

  // Select the transform applied to the newest word for the next index.
  always_comb begin
    temp = newest;
    if (use_rcon) begin
      temp = sw_out ^ {rcon, 24'h0};
    end else if (NK == 8 && phase == 3'd4) begin
      temp = sw_out;
    end
  end

  assign exp_word = oldest ^ temp;

  // Pick the key word that follows the current one while still loading.
  always_comb begin
    load_word = '0;
    for (int j = 0; j < NK; j++) begin
      if (word_idx + 6'd1 == 6'(j)) load_word = window[j];
    end
  end

  assign next_word = from_key ? load_word : exp_word;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; abort wins over a simultaneous transfer.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD, EXPAND: begin
        if (abort_req) begin
          state_nxt = IDLE;
        end else if (xfer) begin
          if (word_idx == LAST_IDX)       state_nxt = IDLE;
          else if (word_idx == LOAD_LAST) state_nxt = EXPAND;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: key capture, word advance on transfer, hold on stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wvalid   <= 1'b0;
      word     <= '0;
      word_idx <= '0;
      done     <= 1'b0;
      phase    <= PHASE_INIT;
      rcon     <= RCON_INIT;
      for (int j = 0; j < NK; j++) window[j] <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          for (int j = 0; j < NK; j++) window[j] <= key[32*(NK-j)-1 -: 32];
          word     <= key[32*NK-1 -: 32];
          word_idx <= '0;
          phase    <= PHASE_INIT;
          rcon     <= RCON_INIT;
          wvalid   <= 1'b1;
        end
      end else if (abort_req) begin
        wvalid <= 1'b0;
      end else if (xfer) begin
        if (word_idx == LAST_IDX) begin
          wvalid <= 1'b0;
          done   <= 1'b1;
        end else begin
          word     <= next_word;
          word_idx <= word_idx + 6'd1;
          phase    <= (phase == PHASE_LAST) ? 3'd0 : phase + 3'd1;
          if (!from_key) begin
            for (int j = 0; j < NK - 1; j++) window[j] <= window[j+1];
            window[NK-1] <= exp_word;
            if (use_rcon) rcon <= xtime(rcon);
          end
        end
      end
    end
  end

endmodule
